// File: rtl/ps2_matrix_ctl.sv
// ps2_matrix_ctl
//   Sits between the PS/2 byte receiver and the scan2matrix translator.
//   It strips E0/F0 prefixes and tracks shift/ctrl/rus itself. Every other
//   scancode goes to the translator, one at a time. The translated cells are
//   held in a small key table. That table drives a Vector-06C 8x8 keyboard
//   matrix that the CPU reads through rowselect/rowbits.
//
// Ports
//   c, reset_n             clock, asynchronous active-low reset
//   rx_data, rx_valid      received PS/2 byte and its one-cycle strobe
//   tr_scancode/shift/rus  request presented to the translator
//   tr_row/col/xshift/err  translator result, registered one cycle later
//   rowselect, rowbits     CPU matrix scan, both active-low
//   key_shift/ctrl/rus     Vector modifier lines, active-high
//   busy                   sequencer is not in READY; bytes are dropped
//   o_blkvvod, o_blksbr    reset-request pulses (F11 / F12)
//
// Build option
//   KBD_RESETKEYS_EN  when defined, the makes of F11 (78) and F12 (07) pulse
//                     o_blkvvod / o_blksbr instead of reaching the translator.
//
// Handshake: rx_valid is a one-cycle strobe with no back-pressure. A byte is
// taken only while busy=0; a byte strobed while busy=1 is lost without
// touching the prefix flags.
module ps2_matrix_ctl #(
    parameter int SLOTS = 4
) (
    input  logic       c,
    input  logic       reset_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tr_scancode,
    output logic       tr_shift,
    output logic       tr_rus,
    input  logic [2:0] tr_row,
    input  logic [2:0] tr_col,
    input  logic       tr_xshift,
    input  logic       tr_error,
    input  logic [7:0] rowselect,
    output logic [7:0] rowbits,
    output logic       key_shift,
    output logic       key_ctrl,
    output logic       key_rus,
    output logic       busy,
    output logic       o_blkvvod,
    output logic       o_blksbr
);

    localparam logic [1:0] ST_READY = 2'd0;
    localparam logic [1:0] ST_XLAT  = 2'd1;
    localparam logic [1:0] ST_APPLY = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             e0_q, e0_d;
    logic             f0_q, f0_d;
    logic             shift_held_q, shift_held_d;
    logic             ctrl_q, ctrl_d;
    logic             rus_q, rus_d;
    logic [7:0]       tr_scancode_q, tr_scancode_d;
    logic             tr_shift_q, tr_shift_d;
    logic             tr_rus_q, tr_rus_d;
    logic             brk_q, brk_d;

    // The key table. Each slot keeps the cell its make produced. A break can
    // therefore clear exactly that cell, even if the shift state changed.
    logic [SLOTS-1:0] slot_valid_q, slot_valid_d;
    logic [7:0]       slot_code_q [SLOTS];
    logic [7:0]       slot_code_d [SLOTS];
    logic [2:0]       slot_row_q  [SLOTS];
    logic [2:0]       slot_row_d  [SLOTS];
    logic [2:0]       slot_col_q  [SLOTS];
    logic [2:0]       slot_col_d  [SLOTS];
    logic [SLOTS-1:0] slot_xs_q, slot_xs_d;

    logic             hit;
    logic             placed;
    logic [7:0]       cell_or;
    logic             xs_any;

`ifdef KBD_RESETKEYS_EN
    logic             blkvvod_q, blkvvod_d;
    logic             blksbr_q, blksbr_d;
`endif

    always_comb begin
        state_d       = state_q;
        e0_d          = e0_q;
        f0_d          = f0_q;
        shift_held_d  = shift_held_q;
        ctrl_d        = ctrl_q;
        rus_d         = rus_q;
        tr_scancode_d = tr_scancode_q;
        tr_shift_d    = tr_shift_q;
        tr_rus_d      = tr_rus_q;
        brk_d         = brk_q;
        slot_valid_d  = slot_valid_q;
        slot_code_d   = slot_code_q;
        slot_row_d    = slot_row_q;
        slot_col_d    = slot_col_q;
        slot_xs_d     = slot_xs_q;
        hit           = 1'b0;
        placed        = 1'b0;
`ifdef KBD_RESETKEYS_EN
        blkvvod_d     = 1'b0;
        blksbr_d      = 1'b0;
`endif
        case (state_q)
            ST_READY: begin
                if (rx_valid) begin
                    if (rx_data == 8'hE0) begin
                        e0_d = 1'b1;
                    end else if (rx_data == 8'hF0) begin
                        f0_d = 1'b1;
                    end else begin
                        e0_d = 1'b0;
                        f0_d = 1'b0;
                        if (rx_data == 8'h12 || rx_data == 8'h59) begin
                            // E0 12 is the fake shift sent around the
                            // extended keys, so it is ignored here.
                            if (!e0_q) shift_held_d = !f0_q;
                        end else if (rx_data == 8'h14) begin
                            ctrl_d = !f0_q;
                        end else if (rx_data == 8'h58) begin
                            rus_d = !f0_q;
`ifdef KBD_RESETKEYS_EN
                        end else if (rx_data == 8'h78) begin
                            blkvvod_d = !f0_q;
                        end else if (rx_data == 8'h07) begin
                            blksbr_d = !f0_q;
`endif
                        end else begin
                            tr_scancode_d = rx_data;
                            tr_shift_d    = shift_held_q;
                            tr_rus_d      = rus_q;
                            brk_d         = f0_q;
                            state_d       = ST_XLAT;
                        end
                    end
                end
            end
            ST_XLAT: begin
                // The translator registers its answer during this cycle.
                state_d = ST_APPLY;
            end
            ST_APPLY: begin
                state_d = ST_READY;
                for (int i = 0; i < SLOTS; i++) begin
                    if (slot_valid_q[i] && slot_code_q[i] == tr_scancode_q) hit = 1'b1;
                end
                for (int i = 0; i < SLOTS; i++) begin
                    if (brk_q) begin
                        if (slot_valid_q[i] && slot_code_q[i] == tr_scancode_q)
                            slot_valid_d[i] = 1'b0;
                    end else if (!hit && !tr_error && !placed && !slot_valid_q[i]) begin
                        // The lowest free slot wins. A full table drops the make.
                        placed          = 1'b1;
                        slot_valid_d[i] = 1'b1;
                        slot_code_d[i]  = tr_scancode_q;
                        slot_row_d[i]   = tr_row;
                        slot_col_d[i]   = tr_col;
                        slot_xs_d[i]    = tr_xshift;
                    end
                end
            end
            default: state_d = ST_READY;
        endcase
    end

    always_ff @(posedge c or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_READY;
            e0_q          <= 1'b0;
            f0_q          <= 1'b0;
            shift_held_q  <= 1'b0;
            ctrl_q        <= 1'b0;
            rus_q         <= 1'b0;
            tr_scancode_q <= 8'h00;
            tr_shift_q    <= 1'b0;
            tr_rus_q      <= 1'b0;
            brk_q         <= 1'b0;
            slot_valid_q  <= '0;
            slot_xs_q     <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                slot_code_q[i] <= 8'h00;
                slot_row_q[i]  <= 3'd0;
                slot_col_q[i]  <= 3'd0;
            end
        end else begin
            state_q       <= state_d;
            e0_q          <= e0_d;
            f0_q          <= f0_d;
            shift_held_q  <= shift_held_d;
            ctrl_q        <= ctrl_d;
            rus_q         <= rus_d;
            tr_scancode_q <= tr_scancode_d;
            tr_shift_q    <= tr_shift_d;
            tr_rus_q      <= tr_rus_d;
            brk_q         <= brk_d;
            slot_valid_q  <= slot_valid_d;
            slot_xs_q     <= slot_xs_d;
            slot_code_q   <= slot_code_d;
            slot_row_q    <= slot_row_d;
            slot_col_q    <= slot_col_d;
        end
    end

`ifdef KBD_RESETKEYS_EN
    always_ff @(posedge c or negedge reset_n) begin
        if (!reset_n) begin
            blkvvod_q <= 1'b0;
            blksbr_q  <= 1'b0;
        end else begin
            blkvvod_q <= blkvvod_d;
            blksbr_q  <= blksbr_d;
        end
    end
    assign o_blkvvod = blkvvod_q;
    assign o_blksbr  = blksbr_q;
`else
    assign o_blkvvod = 1'b0;
    assign o_blksbr  = 1'b0;
`endif

    // Matrix readback is combinational, so the CPU sees a new rowselect at once.
    always_comb begin
        cell_or = 8'h00;
        xs_any  = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (slot_valid_q[i]) begin
                if (!rowselect[slot_row_q[i]]) cell_or[slot_col_q[i]] = 1'b1;
                if (slot_xs_q[i]) xs_any = 1'b1;
            end
        end
    end

    assign rowbits     = ~cell_or;
    assign key_shift   = shift_held_q ^ xs_any;
    assign key_ctrl    = ctrl_q;
    assign key_rus     = rus_q;
    assign busy        = (state_q != ST_READY);
    assign tr_scancode = tr_scancode_q;
    assign tr_shift    = tr_shift_q;
    assign tr_rus      = tr_rus_q;

endmodule
